dlms_stimulus_gen: RTL
======================

DLMS_STIMULUS_GEN -- requirements
Module: dlms_stimulus_gen

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- W1, 8, sample and coefficient width.
- LW, 16, LFSR width.
- SEED, 16'hACE1, LFSR reset/restart value; must be non-zero.
- AMP, 64, magnitude of x samples.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, level; sampled only in IDLE.
- plant0, in, W1 signed, plant tap 0.
- plant1, in, W1 signed, plant tap 1.
- n_samples, in, 16 unsigned, burst length.
- x_out, out, W1 signed, reference input for the DLMS filter.
- d_out, out, W1 signed, desired signal for the DLMS filter.
- valid, out, 1, x_out/d_out pair is valid this cycle.
- busy, out, 1, high in RUN.
- done, out, 1, single-cycle pulse at end of burst.

Function
REQ-003 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-004 SHALL go IDLE->RUN on start=1 and, at that edge, SHALL:
- latch plant0, plant1 and n_samples;
- load LFSR=SEED;
- clear x_prev and the sample counter.
REQ-005 SHALL go IDLE->DONE directly when start=1 and n_samples=0; no valid is emitted.
REQ-006 SHALL ignore start while in RUN or DONE.
REQ-007 SHALL register all outputs; the first valid cycle is the cycle immediately after the cycle in which start was sampled high.
REQ-008 In RUN, SHALL emit exactly one sample per cycle with valid=1, with no gaps.
REQ-009 Sample k SHALL be x[k]=+AMP if LFSR bit0=1, else -AMP.
REQ-010 After each sample, the LFSR SHALL shift as a Fibonacci LFSR: new bit = l[15]^l[13]^l[12]^l[10]; lfsr <= {l[14:0], new}.
REQ-011 SHALL compute d[k] = sat_W1((plant0*x[k] + plant1*x[k-1]) >>> 7), with x[-1]=0.
- Products: 2*W1 bits; sum: 2*W1+1 bits.
- Shift: arithmetic.
- Saturation: to [-2^(W1-1), 2^(W1-1)-1].
REQ-012 SHALL present d[k] in the same cycle as x[k] (aligned pair, zero relative skew).
REQ-013 After sample n_samples-1, SHALL enter DONE; valid=0 in the DONE cycle.
REQ-014 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-015 n_samples=65535 SHALL produce 65535 samples with no counter wrap.
REQ-016 Outside RUN, SHALL hold x_out and d_out at 0 and drive valid=0.
REQ-017 Changes on plant0/plant1/n_samples during RUN SHALL have no effect until the next start.

Reset
REQ-018 reset=1 SHALL, at the next edge and overriding all other inputs including start:
- force state IDLE;
- set LFSR=SEED;
- clear the counter and x_prev;
- drive x_out=0, d_out=0, valid=0, busy=0, done=0.
REQ-019 reset asserted mid-RUN SHALL abort the burst with no done pulse; the next start SHALL restart the identical sequence from SEED.

Structure
REQ-020 SHALL place the state encoding, SEED, AMP and the LFSR tap positions in shared package dlms_pkg, reused by the DLMS filter bench.
REQ-021 SHALL instantiate one sub-module, lfsr_bit_gen (LFSR register plus shift enable and load), inside this block; the plant arithmetic stays inline.

Verification
REQ-022 SHALL cover, each as stimulus -> required response:
- start, plant0=64, plant1=0, n_samples=4 -> four valid cycles; first x=+64, d=32; sign of d follows x; then one done pulse, then IDLE.
- plant0=127, plant1=127, SEED defaults -> first two samples x=+64,+64 give d=63 then d=127.
- plant0=-128, plant1=-128, forced x=-64 on two consecutive samples -> d saturates to 127, no wrap.
- n_samples=0 with start -> DONE one cycle later, valid never asserted.
- reset after 3 of 10 samples, then restart -> no done pulse; restarted x sequence bit-identical to the first run.
- start held high through RUN -> exactly n_samples outputs; a new burst begins only from IDLE.

Source files
------------

// File: rtl/dlms_pkg.sv
// Shared constants for the DLMS stimulus generator and the DLMS filter bench:
// FSM encoding, LFSR seed and taps, reference amplitude and plant output shift.
package dlms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          X_AMP     = 64;
    localparam int          D_SHIFT   = 7;

    // Fibonacci feedback taps: new bit = l[15]^l[13]^l[12]^l[10]
    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

endpackage

// File: rtl/lfsr_bit_gen.sv
// Fibonacci LFSR with synchronous load to SEED and shift enable; exposes bit0
// of the state the register will hold after the next shift.
module lfsr_bit_gen
    import dlms_pkg::*;
#(
    parameter int             LW   = 16,
    parameter logic [LW-1:0]  SEED = LW'(LFSR_SEED)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic nxt_bit
);

    logic [LW-1:0] q;
    logic [LW-1:0] nxt;

    always_comb begin
        nxt     = {q[LW-2:0], q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D]};
        nxt_bit = nxt[0];
    end

    always_ff @(posedge clk) begin
        if (reset || load)
            q <= SEED;
        else if (en)
            q <= nxt;
    end

endmodule

// File: rtl/dlms_stimulus_gen.sv
// Burst generator for DLMS experiments: +/-AMP pseudo-random reference x and the
// matching two-tap plant output d, emitted as a registered, aligned pair.
module dlms_stimulus_gen
    import dlms_pkg::*;
#(
    parameter int             W1   = 8,
    parameter int             LW   = 16,
    parameter logic [LW-1:0]  SEED = LW'(LFSR_SEED),
    parameter int             AMP  = X_AMP
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [W1-1:0] plant0,
    input  logic signed [W1-1:0] plant1,
    input  logic [15:0]          n_samples,
    output logic signed [W1-1:0] x_out,
    output logic signed [W1-1:0] d_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 done
);

    localparam logic signed [W1-1:0]   XP   = W1'(AMP);
    localparam logic signed [W1-1:0]   XN   = -XP;
    localparam logic signed [W1-1:0]   SMAX = {1'b0, {(W1-1){1'b1}}};
    localparam logic signed [W1-1:0]   SMIN = {1'b1, {(W1-1){1'b0}}};
    localparam logic signed [2*W1:0]   DMAX = (2*W1+1)'(SMAX);
    localparam logic signed [2*W1:0]   DMIN = (2*W1+1)'(SMIN);

    state_t                 state;
    logic signed [W1-1:0]   p0_q, p1_q;
    logic [15:0]            n_q;
    logic [15:0]            cnt;

    logic                   lfsr_load, lfsr_en, lfsr_bit;
    logic                   smp_bit;
    logic signed [W1-1:0]   pa, pb, xp, x_nxt, d_nxt;
    logic signed [2*W1-1:0] prod0, prod1;
    logic signed [2*W1:0]   acc, sh;
    logic                   last;

    assign last      = (cnt == n_q - 16'd1);
    assign lfsr_load = (state == ST_IDLE) && start;
    assign lfsr_en   = (state == ST_RUN) && !last;

    lfsr_bit_gen #(.LW(LW), .SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .en      (lfsr_en),
        .nxt_bit (lfsr_bit)
    );

    // In IDLE the first sample is built from SEED and the live plant inputs
    // with x[-1]=0; in RUN the registered x_out doubles as x[k-1].
    always_comb begin
        smp_bit = SEED[0];
        pa      = plant0;
        pb      = plant1;
        xp      = '0;
        if (state == ST_RUN) begin
            smp_bit = lfsr_bit;
            pa      = p0_q;
            pb      = p1_q;
            xp      = x_out;
        end
        x_nxt = smp_bit ? XP : XN;
        prod0 = (2*W1)'(pa) * (2*W1)'(x_nxt);
        prod1 = (2*W1)'(pb) * (2*W1)'(xp);
        acc   = (2*W1+1)'(prod0) + (2*W1+1)'(prod1);
        sh    = acc >>> D_SHIFT;
        if (sh > DMAX)
            d_nxt = SMAX;
        else if (sh < DMIN)
            d_nxt = SMIN;
        else
            d_nxt = sh[W1-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            p0_q  <= '0;
            p1_q  <= '0;
            n_q   <= '0;
            cnt   <= '0;
            x_out <= '0;
            d_out <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        p0_q <= plant0;
                        p1_q <= plant1;
                        n_q  <= n_samples;
                        cnt  <= '0;
                        if (n_samples == 16'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            valid <= 1'b1;
                            x_out <= x_nxt;
                            d_out <= d_nxt;
                        end
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                        done  <= 1'b1;
                        x_out <= '0;
                        d_out <= '0;
                    end else begin
                        cnt   <= cnt + 16'd1;
                        x_out <= x_nxt;
                        d_out <= d_nxt;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                    done  <= 1'b0;
                    x_out <= '0;
                    d_out <= '0;
                end
            endcase
        end
    end

endmodule
